// File: rtl/pixel_frame_sequencer.sv
// Frame sequencer: holds ledindex for COMPUTE_CYCLES, captures {red,green,blue}, offers it, then idles a latch gap.
// Pixel handshake is valid/ready; a stalled serializer stretches the frame but never drops or skips a pixel.
module pixel_frame_sequencer #(
   parameter int NUM_LEDS       = 50,
   parameter int COMPUTE_CYCLES = 64,
   parameter int LATCH_CYCLES   = 2400
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   output logic [7:0]  ledindex,
   input  logic [7:0]  red,
   input  logic [7:0]  green,
   input  logic [7:0]  blue,
   output logic        px_valid,
   output logic [23:0] px_data,
   input  logic        px_ready,
   output logic        frame_done,
   output logic [15:0] frame_count,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, COMPUTE, OFFER, LATCH} state_t;

   localparam logic [7:0]  LAST_LED     = 8'(NUM_LEDS - 1);
   localparam logic [15:0] COMPUTE_LAST = 16'(COMPUTE_CYCLES - 1);
   localparam logic [15:0] LATCH_LAST   = 16'(LATCH_CYCLES - 1);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  ledindex_q, ledindex_d;
   logic        px_valid_q, px_valid_d;
   logic [23:0] px_data_q, px_data_d;
   logic        frame_done_q, frame_done_d;
   logic [15:0] frame_count_q, frame_count_d;
   logic        busy_q, busy_d;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      ledindex_d    = ledindex_q;
      px_valid_d    = px_valid_q;
      px_data_d     = px_data_q;
      frame_done_d  = 1'b0;
      frame_count_d = frame_count_q;

      unique case (state_q)
         IDLE: begin
            if (enable) begin
               state_d    = COMPUTE;
               cnt_d      = 16'd0;
               ledindex_d = 8'd0;
            end
         end
         COMPUTE: begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == COMPUTE_LAST) begin
               px_data_d  = {red, green, blue};
               px_valid_d = 1'b1;
               state_d    = OFFER;
            end
         end
         OFFER: begin
            if (px_valid_q && px_ready) begin
               px_valid_d = 1'b0;
               cnt_d      = 16'd0;
               // Last pixel leaves ledindex alone so a 256-LED string never wraps to 0 early.
               if (ledindex_q == LAST_LED) begin
                  state_d = LATCH;
               end else begin
                  ledindex_d = ledindex_q + 8'd1;
                  state_d    = COMPUTE;
               end
            end
         end
         LATCH: begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == LATCH_LAST) begin
               frame_done_d  = 1'b1;
               frame_count_d = frame_count_q + 16'd1;
               cnt_d         = 16'd0;
               ledindex_d    = 8'd0;
               state_d       = enable ? COMPUTE : IDLE;
            end
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= 16'd0;
         ledindex_q    <= 8'd0;
         px_valid_q    <= 1'b0;
         px_data_q     <= 24'd0;
         frame_done_q  <= 1'b0;
         frame_count_q <= 16'd0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         ledindex_q    <= ledindex_d;
         px_valid_q    <= px_valid_d;
         px_data_q     <= px_data_d;
         frame_done_q  <= frame_done_d;
         frame_count_q <= frame_count_d;
         busy_q        <= busy_d;
      end
   end

   assign ledindex    = ledindex_q;
   assign px_valid    = px_valid_q;
   assign px_data     = px_data_q;
   assign frame_done  = frame_done_q;
   assign frame_count = frame_count_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Bench for pixel_frame_sequencer: directed scenarios plus random enable/ready/reset against a timeline model.
// A second instance with a single LED runs free alongside to check its fixed frame period.
module tb_pixel_frame_sequencer;
   localparam int N  = 3;
   localparam int CC = 4;
   localparam int LC = 10;

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, enable, px_ready;
   logic [7:0]  red, green, blue;
   logic [7:0]  ledindex;
   logic        px_valid, frame_done, busy;
   logic [23:0] px_data;
   logic [15:0] frame_count;

   logic        rst1_n, en1, rdy1;
   logic [7:0]  ledindex1;
   logic        px_valid1, frame_done1, busy1;
   logic [23:0] px_data1;
   logic [15:0] frame_count1;

   pixel_frame_sequencer #(.NUM_LEDS(N), .COMPUTE_CYCLES(CC), .LATCH_CYCLES(LC)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .ledindex(ledindex),
      .red(red), .green(green), .blue(blue),
      .px_valid(px_valid), .px_data(px_data), .px_ready(px_ready),
      .frame_done(frame_done), .frame_count(frame_count), .busy(busy)
   );

   pixel_frame_sequencer #(.NUM_LEDS(1), .COMPUTE_CYCLES(CC), .LATCH_CYCLES(LC)) dut1 (
      .clk(clk), .rst_n(rst1_n), .enable(en1), .ledindex(ledindex1),
      .red(red), .green(green), .blue(blue),
      .px_valid(px_valid1), .px_data(px_data1), .px_ready(rdy1),
      .frame_done(frame_done1), .frame_count(frame_count1), .busy(busy1)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Colour datapath stand-in: a pure function of the pixel index.
   logic [7:0] r_off, g_val, b_val, b_step;
   function automatic logic [23:0] colour(input logic [7:0] idx);
      logic [7:0] r, b;
      r = r_off + idx;
      b = b_val + 8'(b_step * idx);
      return {r, g_val, b};
   endfunction

   // Timeline model: a frame is N rounds of (CC cycles wait, offer until taken), then LC cycles gap.
   bit          m_busy, m_valid, m_done, m_gap;
   int          m_left;
   logic [7:0]  m_idx;
   logic [23:0] m_data;
   logic [15:0] m_fc;

   task automatic model_step(input logic en, input logic rdy, input logic rst);
      if (!rst) begin
         m_busy = 0; m_valid = 0; m_done = 0; m_gap = 0; m_left = 0;
         m_idx = 8'd0; m_data = 24'd0; m_fc = 16'd0;
         return;
      end
      m_done = 0;
      if (!m_busy) begin
         if (en) begin
            m_busy = 1; m_idx = 8'd0; m_left = CC; m_gap = 0;
         end
      end else if (m_valid) begin
         if (rdy) begin
            m_valid = 0;
            if (int'(m_idx) == N - 1) begin
               m_gap = 1; m_left = LC;
            end else begin
               m_idx = m_idx + 8'd1; m_left = CC;
            end
         end
      end else begin
         m_left = m_left - 1;
         if (m_left == 0) begin
            if (m_gap) begin
               m_done = 1; m_fc = m_fc + 16'd1; m_idx = 8'd0; m_gap = 0;
               if (en) m_left = CC;
               else    m_busy = 0;
            end else begin
               m_valid = 1; m_data = colour(m_idx);
            end
         end
      end
   endtask

   logic [23:0] acc_q[$];
   int last_acc_edge = 0, last_done_edge = 0, vld_seen = 0;
   logic prev_done = 1'b0;
   int last_done1 = -1, vld1_cnt = 0, n1_frames = 0;
   logic idx1_nz = 1'b0;

   task automatic step(input logic en, input logic rdy, input logic rst);
      enable = en; px_ready = rdy; rst_n = rst;
      {red, green, blue} = colour(ledindex);
      if (rst && px_valid && rdy) begin
         acc_q.push_back(px_data);
         last_acc_edge = cyc + 1;
      end
      model_step(en, rdy, rst);
      @(posedge clk);
      #1;
      cyc++;
      chk("busy",   32'(busy),        32'(m_busy));
      chk("valid",  32'(px_valid),    32'(m_valid));
      chk("data",   32'(px_data),     32'(m_data));
      chk("index",  32'(ledindex),    32'(m_idx));
      chk("done",   32'(frame_done),  32'(m_done));
      chk("fcount", 32'(frame_count), 32'(m_fc));
      chk("done_consec", 32'(prev_done & frame_done), 32'd0);
      prev_done = frame_done;
      if (px_valid) vld_seen++;
      if (frame_done) last_done_edge = cyc;
      if (frame_done1) begin
         if (last_done1 >= 0) begin
            chk("n1_period", 32'(cyc - last_done1), 32'(CC + 1 + LC));
            chk("n1_pixels", 32'(vld1_cnt), 32'd1);
         end
         last_done1 = cyc; vld1_cnt = 0; n1_frames++;
      end
      if (px_valid1) vld1_cnt++;
      if (ledindex1 != 8'd0) idx1_nz = 1'b1;
   endtask

   initial begin
      logic ok, hold;
      int held, bp_acc, d_acc2;

      r_off = 8'h10; g_val = 8'h20; b_val = 8'h30; b_step = 8'h00;
      rst_n = 1'b0; enable = 1'b0; px_ready = 1'b0;
      rst1_n = 1'b0; en1 = 1'b0; rdy1 = 1'b1;
      red = 8'd0; green = 8'd0; blue = 8'd0;

      repeat (3) step(1'b1, 1'b1, 1'b0);
      chk("rst_busy",  32'(busy),        32'd0);
      chk("rst_valid", 32'(px_valid),    32'd0);
      chk("rst_fc",    32'(frame_count), 32'd0);
      rst1_n = 1'b1; en1 = 1'b1;
      step(1'b0, 1'b1, 1'b1);

      // Nominal frame with the serializer always ready.
      acc_q.delete(); vld_seen = 0; ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         step(1'b1, 1'b1, 1'b1);
         if (frame_done) ok = 1'b1;
      end
      chk("nom_done",  32'(ok), 32'd1);
      chk("nom_count", 32'(acc_q.size()), 32'd3);
      chk("nom_px0",   32'(acc_q[0]), 32'h102030);
      chk("nom_px1",   32'(acc_q[1]), 32'h112030);
      chk("nom_px2",   32'(acc_q[2]), 32'h122030);
      chk("nom_gap",   32'(last_done_edge - last_acc_edge), 32'(LC));
      chk("nom_vld",   32'(vld_seen), 32'd3);
      chk("nom_fc",    32'(frame_count), 32'd1);

      // Backpressure: hold off pixel 1 for seven cycles.
      held = 0; bp_acc = 0; ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         hold = m_valid && m_idx == 8'd1 && held < 7;
         if (hold) begin
            chk("bp_valid", 32'(px_valid), 32'd1);
            chk("bp_data",  32'(px_data),  32'(colour(8'd1)));
            chk("bp_index", 32'(ledindex), 32'd1);
            held++;
         end
         if (px_valid && !hold && ledindex == 8'd1) bp_acc++;
         step(1'b1, !hold, 1'b1);
         if (held == 7 && frame_done) ok = 1'b1;
      end
      chk("bp_done",    32'(ok), 32'd1);
      chk("bp_held",    32'(held), 32'd7);
      chk("bp_accepts", 32'(bp_acc), 32'd1);

      // Drop enable while pixel 1 is being computed.
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         if (m_busy && !m_valid && !m_gap && m_idx == 8'd1) ok = 1'b1;
         else step(1'b1, 1'b1, 1'b1);
      end
      chk("dis_reach", 32'(ok), 32'd1);
      d_acc2 = 0; ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         if (px_valid && ledindex == 8'd2) d_acc2++;
         step(1'b0, 1'b1, 1'b1);
         if (frame_done) ok = 1'b1;
      end
      chk("dis_done", 32'(ok), 32'd1);
      chk("dis_px2",  32'(d_acc2), 32'd1);
      vld_seen = 0;
      repeat (20) step(1'b0, 1'b1, 1'b1);
      chk("dis_busy",    32'(busy), 32'd0);
      chk("dis_novalid", 32'(vld_seen), 32'd0);

      // Reset while a pixel is pending.
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         if (m_valid) ok = 1'b1;
         else step(1'b1, 1'b0, 1'b1);
      end
      chk("rmo_reach", 32'(ok), 32'd1);
      step(1'b1, 1'b1, 1'b0);
      chk("rmo_valid", 32'(px_valid),    32'd0);
      chk("rmo_data",  32'(px_data),     32'd0);
      chk("rmo_busy",  32'(busy),        32'd0);
      chk("rmo_fc",    32'(frame_count), 32'd0);

      // Frame counter wrap in continuous mode.
      repeat (3) step(1'b1, 1'b1, 1'b1);
      force dut.frame_count_q = 16'hFFFF;
      m_fc = 16'hFFFF;
      step(1'b1, 1'b1, 1'b1);
      release dut.frame_count_q;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         step(1'b1, 1'b1, 1'b1);
         if (frame_done) ok = 1'b1;
      end
      chk("wrap_done",  32'(ok), 32'd1);
      chk("wrap_fc",    32'(frame_count), 32'd0);
      chk("wrap_busy",  32'(busy), 32'd1);
      chk("wrap_index", 32'(ledindex), 32'd0);
      step(1'b1, 1'b1, 1'b1);
      chk("wrap_next_busy",  32'(busy), 32'd1);
      chk("wrap_next_valid", 32'(px_valid), 32'd0);

      // Random enable, ready and occasional reset.
      for (int blk = 0; blk < 10; blk++) begin
         r_off = 8'($urandom); g_val = 8'($urandom); b_val = 8'($urandom); b_step = 8'($urandom);
         for (int i = 0; i < 200; i++)
            step($urandom_range(0, 19) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 299) != 0);
      end

      chk("n1_index0", 32'(idx1_nz), 32'd0);
      chk("n1_frames", 32'(n1_frames > 10), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
